puck_ctl: RTL and testbench

Frame-rate game controller for the air hockey display pipeline. It sequences puck motion, wall and paddle bounces, goal detection, scoring and match phases once per video frame, synchronised to the blanking signal of the VGA timing chain. It drives the position and score registers consumed by the downstream draw stages. It runs in the pixel clock domain alongside the timing and background stages.

---
 rtl/puck_ctl.sv | 231 +++++++++++++++++++++++
 tb/tb_puck_ctl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puck_ctl.sv
// puck_ctl: once-per-frame air hockey game sequencer.
// Moves the puck, bounces it off walls and paddles, detects goals, keeps
// score and steps through the IDLE/PLAY/GOAL/OVER match phases. Every
// update happens one cycle after vertical blank is first seen high.
module puck_ctl #(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int PUCK_SIZE    = 32,
    parameter int GOAL_TOP     = 256,
    parameter int GOAL_BOT     = 512,
    parameter int START_VX     = 4,
    parameter int START_VY     = 3,
    parameter int PAUSE_FRAMES = 120,
    parameter int WIN_SCORE    = 7
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        hit_left,
    input  logic        hit_right,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic [1:0]  state,
    output logic        goal
);

    localparam logic [11:0]        CENTRE_X   = 12'((H_ACTIVE - PUCK_SIZE) / 2);
    localparam logic [11:0]        CENTRE_Y   = 12'((V_ACTIVE - PUCK_SIZE) / 2);
    localparam logic [11:0]        X_MAX      = 12'(H_ACTIVE - PUCK_SIZE);
    localparam logic [11:0]        Y_MAX      = 12'(V_ACTIVE - PUCK_SIZE);
    localparam logic signed [12:0] X_MAX13    = 13'(H_ACTIVE - PUCK_SIZE);
    localparam logic signed [12:0] Y_MAX13    = 13'(V_ACTIVE - PUCK_SIZE);
    localparam logic [12:0]        MOUTH_TOP  = 13'(GOAL_TOP);
    localparam logic [12:0]        MOUTH_BOT  = 13'(GOAL_BOT);
    localparam logic [12:0]        PUCK13     = 13'(PUCK_SIZE);
    localparam logic signed [7:0]  VX_SERVE   = 8'(START_VX);
    localparam logic signed [7:0]  VY_SERVE   = 8'(START_VY);
    localparam logic [7:0]         PAUSE_LAST = 8'(PAUSE_FRAMES - 1);
    localparam logic [3:0]         WIN4       = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GOAL = 2'd2,
        OVER = 2'd3
    } gameState_t;

    gameState_t r_state, w_stateNext;

    logic              r_vblnkSync, r_vblnkDly, r_armed;
    logic [11:0]       r_x, r_y;
    logic signed [7:0] r_vx, r_vy;
    logic [3:0]        r_scoreLeft, r_scoreRight;
    logic [7:0]        r_pause;
    logic              r_serveLeft;
    logic              r_goal;

    logic              w_tick;
    logic signed [7:0] w_vxLeft, w_vxHit;
    logic signed [12:0] w_nx, w_ny;
    logic              w_inMouth, w_rightScores, w_leftScores, w_scored, w_win;
    logic [3:0]        w_scoreLeftInc, w_scoreRightInc;

    logic [11:0]       w_xNext, w_yNext;
    logic signed [7:0] w_vxNext, w_vyNext;
    logic [3:0]        w_scoreLeftNext, w_scoreRightNext;
    logic [7:0]        w_pauseNext;
    logic              w_serveLeftNext, w_goalNext;

    // The tick needs a low-to-high transition seen after reset, so a blank
    // already in progress at reset release is skipped until the next frame.
    assign w_tick = r_vblnkSync & ~r_vblnkDly & r_armed;

    // Register the blank input twice and arm once it has been seen low.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_vblnkSync <= 1'b0;
            r_vblnkDly  <= 1'b0;
            r_armed     <= 1'b0;
        end else begin
            r_vblnkSync <= vblnk_in;
            r_vblnkDly  <= r_vblnkSync;
            r_armed     <= r_armed | ~vblnk_in;
        end
    end

    // Candidate motion for this frame: paddle deflection, then edge tests.
    always_comb begin
        w_vxLeft  = (hit_left && (r_vx < 0)) ? -r_vx : r_vx;
        w_vxHit   = (hit_right && (w_vxLeft > 0)) ? -w_vxLeft : w_vxLeft;
        w_nx      = $signed({1'b0, r_x}) + $signed({{5{w_vxHit[7]}}, w_vxHit});
        w_ny      = $signed({1'b0, r_y}) + $signed({{5{r_vy[7]}}, r_vy});
        w_inMouth = ({1'b0, r_y} >= MOUTH_TOP) && (({1'b0, r_y} + PUCK13) <= MOUTH_BOT);
        w_rightScores    = w_inMouth && (w_nx <= 13'sd0);
        w_leftScores     = w_inMouth && (w_nx >= X_MAX13);
        w_scored         = w_tick && (r_state == PLAY) && (w_rightScores || w_leftScores);
        w_scoreLeftInc   = (r_scoreLeft == 4'hF) ? 4'hF : r_scoreLeft + 4'd1;
        w_scoreRightInc  = (r_scoreRight == 4'hF) ? 4'hF : r_scoreRight + 4'd1;
        w_win            = (w_leftScores && (w_scoreLeftInc >= WIN4)) ||
                           (w_rightScores && (w_scoreRightInc >= WIN4));
    end

    // Match phase register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Match phase transitions, evaluated only on frame ticks.
    always_comb begin
        w_stateNext = r_state;
        if (w_tick) begin
            case (r_state)
                IDLE: if (start) w_stateNext = PLAY;
                PLAY: if (w_scored) w_stateNext = w_win ? OVER : GOAL;
                GOAL: if (r_pause == 8'd0) w_stateNext = PLAY;
                OVER: if (start) w_stateNext = IDLE;
                default: w_stateNext = IDLE;
            endcase
        end
    end

    // Next values of position, velocity, scores and pause per phase.
    always_comb begin
        w_xNext          = r_x;
        w_yNext          = r_y;
        w_vxNext         = r_vx;
        w_vyNext         = r_vy;
        w_scoreLeftNext  = r_scoreLeft;
        w_scoreRightNext = r_scoreRight;
        w_pauseNext      = r_pause;
        w_serveLeftNext  = r_serveLeft;
        w_goalNext       = 1'b0;
        if (w_tick) begin
            case (r_state)
                PLAY: begin
                    if (w_scored) begin
                        w_goalNext      = 1'b1;
                        w_pauseNext     = PAUSE_LAST;
                        w_serveLeftNext = w_rightScores;
                        if (w_leftScores) w_scoreLeftNext = w_scoreLeftInc;
                        else              w_scoreRightNext = w_scoreRightInc;
                    end else begin
                        w_vxNext = w_vxHit;
                        if (w_ny <= 13'sd0) begin
                            w_yNext  = 12'd0;
                            w_vyNext = -r_vy;
                        end else if (w_ny >= Y_MAX13) begin
                            w_yNext  = Y_MAX;
                            w_vyNext = -r_vy;
                        end else begin
                            w_yNext = w_ny[11:0];
                        end
                        if (w_nx <= 13'sd0) begin
                            w_xNext  = 12'd0;
                            w_vxNext = -w_vxHit;
                        end else if (w_nx >= X_MAX13) begin
                            w_xNext  = X_MAX;
                            w_vxNext = -w_vxHit;
                        end else begin
                            w_xNext = w_nx[11:0];
                        end
                    end
                end
                GOAL: begin
                    if (r_pause == 8'd0) begin
                        w_xNext  = CENTRE_X;
                        w_yNext  = CENTRE_Y;
                        w_vxNext = r_serveLeft ? -VX_SERVE : VX_SERVE;
                        w_vyNext = VY_SERVE;
                    end else begin
                        w_pauseNext = r_pause - 8'd1;
                    end
                end
                OVER: begin
                    if (start) begin
                        w_scoreLeftNext  = 4'd0;
                        w_scoreRightNext = 4'd0;
                        w_xNext          = CENTRE_X;
                        w_yNext          = CENTRE_Y;
                        w_vxNext         = VX_SERVE;
                        w_vyNext         = VY_SERVE;
                    end
                end
                default: begin
                    w_xNext = CENTRE_X;
                    w_yNext = CENTRE_Y;
                end
            endcase
        end
    end

    // Datapath registers feeding the draw stages.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_x          <= CENTRE_X;
            r_y          <= CENTRE_Y;
            r_vx         <= VX_SERVE;
            r_vy         <= VY_SERVE;
            r_scoreLeft  <= 4'd0;
            r_scoreRight <= 4'd0;
            r_pause      <= 8'd0;
            r_serveLeft  <= 1'b0;
            r_goal       <= 1'b0;
        end else begin
            r_x          <= w_xNext;
            r_y          <= w_yNext;
            r_vx         <= w_vxNext;
            r_vy         <= w_vyNext;
            r_scoreLeft  <= w_scoreLeftNext;
            r_scoreRight <= w_scoreRightNext;
            r_pause      <= w_pauseNext;
            r_serveLeft  <= w_serveLeftNext;
            r_goal       <= w_goalNext;
        end
    end

    assign xpos        = r_x;
    assign ypos        = r_y;
    assign score_left  = r_scoreLeft;
    assign score_right = r_scoreRight;
    assign state       = r_state;
    assign goal        = r_goal;

endmodule

// File: tb/tb_puck_ctl.sv
// tb_puck_ctl: frame-level bench for puck_ctl with a rules-based game model.
module tb_puck_ctl;

    logic        clk_in = 1'b0;
    logic        rst, vblnk_in, start, hit_left, hit_right;
    logic [11:0] xpos, ypos;
    logic [3:0]  score_left, score_right;
    logic [1:0]  state;
    logic        goal;

    int checks   = 0;
    int failures = 0;

    // Game model state in plain integers
    int mX, mY, mVx, mVy, mSL, mSR, mPh, mPause, mGoal;
    bit mServeLeft;

    typedef struct {
        bit s;
        bit hl;
        bit hr;
        int x;
        int y;
        int st;
    } vec_t;

    vec_t vecs[10];

    puck_ctl dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .vblnk_in   (vblnk_in),
        .start      (start),
        .hit_left   (hit_left),
        .hit_right  (hit_right),
        .xpos       (xpos),
        .ypos       (ypos),
        .score_left (score_left),
        .score_right(score_right),
        .state      (state),
        .goal       (goal)
    );

    // Pixel clock
    always #5 clk_in = ~clk_in;

    // One comparison; a mismatch prints a single FAIL line
    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One video frame: blank high for two cycles, low for two; counts goal cycles
    task automatic applyStimulus(input bit s, input bit hl, input bit hr, output int goalCnt);
        goalCnt   = 0;
        start     = s;
        hit_left  = hl;
        hit_right = hr;
        vblnk_in  = 1'b1;
        repeat (2) begin
            @(negedge clk_in);
            if (goal) goalCnt++;
        end
        vblnk_in = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            if (goal) goalCnt++;
        end
    endtask

    task automatic doReset();
        rst       = 1'b1;
        vblnk_in  = 1'b0;
        start     = 1'b0;
        hit_left  = 1'b0;
        hit_right = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    function automatic void modelReset();
        mX = 496; mY = 368; mVx = 4; mVy = 3;
        mSL = 0; mSR = 0; mPh = 0; mPause = 0; mGoal = 0; mServeLeft = 0;
    endfunction

    // Game rules applied once per frame
    function automatic void modelTick(bit s, bit hl, bit hr);
        int nx, ny, scorer;
        bit inMouth, won;
        mGoal = 0;
        case (mPh)
            0: if (s) mPh = 1;
            1: begin
                if (hl && mVx < 0) mVx = -mVx;
                if (hr && mVx > 0) mVx = -mVx;
                nx = mX + mVx;
                ny = mY + mVy;
                inMouth = (mY >= 256) && (mY + 32 <= 512);
                scorer = 0;
                if (inMouth && nx <= 0) scorer = 2;
                else if (inMouth && nx >= 992) scorer = 1;
                if (scorer != 0) begin
                    mGoal = 1;
                    if (scorer == 1) begin
                        mSL = (mSL < 15) ? mSL + 1 : 15;
                        won = (mSL >= 7);
                        mServeLeft = 0;
                    end else begin
                        mSR = (mSR < 15) ? mSR + 1 : 15;
                        won = (mSR >= 7);
                        mServeLeft = 1;
                    end
                    if (won) mPh = 3;
                    else begin mPh = 2; mPause = 119; end
                end else begin
                    if (ny <= 0) begin mY = 0; mVy = -mVy; end
                    else if (ny >= 736) begin mY = 736; mVy = -mVy; end
                    else mY = ny;
                    if (nx <= 0) begin mX = 0; mVx = -mVx; end
                    else if (nx >= 992) begin mX = 992; mVx = -mVx; end
                    else mX = nx;
                end
            end
            2: begin
                if (mPause == 0) begin
                    mX = 496; mY = 368; mVy = 3; mPh = 1;
                    mVx = mServeLeft ? -4 : 4;
                end else begin
                    mPause--;
                end
            end
            default: begin
                if (s) begin
                    mSL = 0; mSR = 0; mX = 496; mY = 368; mVx = 4; mVy = 3; mPh = 0;
                end
            end
        endcase
    endfunction

    task automatic checkModel(input int goalCnt);
        checkOutput("model_xpos",        int'(xpos),        mX);
        checkOutput("model_ypos",        int'(ypos),        mY);
        checkOutput("model_state",       int'(state),       mPh);
        checkOutput("model_score_left",  int'(score_left),  mSL);
        checkOutput("model_score_right", int'(score_right), mSR);
        checkOutput("model_goal_pulses", goalCnt,           mGoal);
    endtask

    initial begin
        int gc, frames, lastX;
        bit s, hl, hr;

        vecs[0] = '{0, 0, 0, 496, 368, 0};
        vecs[1] = '{0, 0, 0, 496, 368, 0};
        vecs[2] = '{0, 0, 0, 496, 368, 0};
        vecs[3] = '{1, 0, 0, 496, 368, 1};
        vecs[4] = '{0, 0, 0, 500, 371, 1};
        vecs[5] = '{0, 0, 0, 504, 374, 1};
        vecs[6] = '{0, 1, 0, 508, 377, 1};
        vecs[7] = '{0, 0, 1, 504, 380, 1};
        vecs[8] = '{1, 0, 0, 500, 383, 1};
        vecs[9] = '{0, 1, 0, 504, 386, 1};

        doReset();
        checkOutput("reset_xpos",  int'(xpos),  496);
        checkOutput("reset_ypos",  int'(ypos),  368);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_goal",  int'(goal),  0);

        // Directed vectors from a fresh reset
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].s, vecs[i].hl, vecs[i].hr, gc);
            checkOutput($sformatf("vec%0d_xpos", i),  int'(xpos),  vecs[i].x);
            checkOutput($sformatf("vec%0d_ypos", i),  int'(ypos),  vecs[i].y);
            checkOutput($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            checkOutput($sformatf("vec%0d_goal", i),  gc,          0);
        end

        // Latency: unchanged one cycle after blank is sampled, updated the next
        modelReset();
        mX = 504; mY = 386; mPh = 1;
        vblnk_in = 1'b1;
        start = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
        @(negedge clk_in);
        checkOutput("latency_before", int'(xpos), 504);
        @(negedge clk_in);
        checkOutput("latency_after", int'(xpos), 508);
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk_in);
        modelTick(0, 0, 0);
        checkModel(0);

        // Random play, first biased toward the left paddle, then the right
        for (int f = 0; f < 4000; f++) begin
            s = ($urandom_range(0, 7) == 0);
            if (f < 2000) begin
                hl = ($urandom_range(0, 3) != 0);
                hr = ($urandom_range(0, 15) == 0);
            end else begin
                hl = ($urandom_range(0, 15) == 0);
                hr = ($urandom_range(0, 3) != 0);
            end
            applyStimulus(s, hl, hr, gc);
            modelTick(s, hl, hr);
            checkModel(gc);
        end

        // Blank already high at reset release gives no tick
        rst = 1'b1; vblnk_in = 1'b1; start = 1'b1; hit_left = 1'b0; hit_right = 1'b0;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        repeat (6) @(negedge clk_in);
        checkOutput("held_blank_state", int'(state), 0);
        vblnk_in = 1'b0;
        repeat (2) @(negedge clk_in);
        applyStimulus(1, 0, 0, gc);
        checkOutput("first_tick_state", int'(state), 1);

        // First goal by the left player, then the pause
        frames = 0;
        gc = 0;
        while (state != 2'd2 && frames < 1000) begin
            applyStimulus(0, 1, 0, gc);
            frames++;
        end
        checkOutput("goal1_state",       int'(state),       2);
        checkOutput("goal1_pulse",       gc,                1);
        checkOutput("goal1_score_left",  int'(score_left),  1);
        checkOutput("goal1_score_right", int'(score_right), 0);
        frames = 0;
        while (state == 2'd2 && frames < 300) begin
            applyStimulus(1, 0, 0, gc);
            frames++;
        end
        checkOutput("pause_frames", frames,      120);
        checkOutput("serve_state",  int'(state), 1);
        checkOutput("serve_xpos",   int'(xpos),  496);
        checkOutput("serve_ypos",   int'(ypos),  368);
        applyStimulus(0, 0, 0, gc);
        checkOutput("serve_dir_x", int'(xpos), 500);
        checkOutput("serve_dir_y", int'(ypos), 371);

        // Play on until the left player wins
        frames = 0;
        while (state != 2'd3 && frames < 5000) begin
            applyStimulus(0, 1, 0, gc);
            frames++;
        end
        checkOutput("over_state",      int'(state),      3);
        checkOutput("over_score_left", int'(score_left), 7);
        lastX = int'(xpos);
        applyStimulus(0, 1, 0, gc);
        applyStimulus(0, 1, 0, gc);
        checkOutput("over_frozen_x",     int'(xpos),  lastX);
        checkOutput("over_frozen_state", int'(state), 3);
        applyStimulus(1, 0, 0, gc);
        checkOutput("restart_state",      int'(state),      0);
        checkOutput("restart_score_left", int'(score_left), 0);
        checkOutput("restart_xpos",       int'(xpos),       496);
        checkOutput("restart_ypos",       int'(ypos),       368);

        // Right player scores, then reset lands in the middle of the pause
        applyStimulus(1, 0, 0, gc);
        frames = 0;
        gc = 0;
        while (state != 2'd2 && frames < 1000) begin
            applyStimulus(0, 0, 1, gc);
            frames++;
        end
        checkOutput("goal2_state",       int'(state),       2);
        checkOutput("goal2_pulse",       gc,                1);
        checkOutput("goal2_score_right", int'(score_right), 1);
        repeat (10) applyStimulus(0, 0, 0, gc);
        #2 rst = 1'b1;
        #1;
        checkOutput("midreset_xpos",        int'(xpos),        496);
        checkOutput("midreset_ypos",        int'(ypos),        368);
        checkOutput("midreset_state",       int'(state),       0);
        checkOutput("midreset_score_right", int'(score_right), 0);
        checkOutput("midreset_goal",        int'(goal),        0);
        @(negedge clk_in);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
